// File: rtl/bcd_timer_ctrl_if.sv
// bcd_timer_ctrl_if: command handshake between a host and the BCD timer controller.
//   cmd_valid/cmd_ready : command handshake, accepted when both are high
//   cmd_op              : 00 START, 01 STOP, 10 CLEAR, 11 LOAD
//   cmd_data            : packed BCD preset for LOAD
//   cmd_dir             : 1 up, 0 down, taken by START from IDLE
interface bcd_timer_ctrl_if #(parameter int DIGITS = 3);
  logic                  cmd_valid;
  logic [1:0]            cmd_op;
  logic [4*DIGITS-1:0]   cmd_data;
  logic                  cmd_dir;
  logic                  cmd_ready;
  modport master (output cmd_valid, cmd_op, cmd_data, cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_dir, output cmd_ready);
endinterface

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: command-driven start/stop/clear/load BCD up/down timer with prescaler.
//   clk, rst : clock, synchronous active-high reset
//   bus      : command handshake (slave side)
//   count    : packed BCD count, digit 0 in [3:0]
//   state    : 0 IDLE, 1 LOAD, 2 RUN, 3 PAUSE, 4 DONE
//   running  : high in RUN
//   done     : one-cycle pulse on terminal count
//   err      : sticky, a LOAD carried a non-BCD digit
module bcd_timer_ctrl #(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_timer_ctrl_if.slave     bus,
  output logic [4*DIGITS-1:0] count,
  output logic [2:0]          state,
  output logic                running,
  output logic                done,
  output logic                err
);
  localparam int W  = 4*DIGITS;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] OP_START = 2'd0, OP_STOP = 2'd1, OP_CLEAR = 2'd2, OP_LOAD = 2'd3;
  typedef enum logic [2:0] {IDLE = 3'd0, LD = 3'd1, RUN = 3'd2, PAUSE = 3'd3, DONE = 3'd4} state_t;
  state_t st, state_n;
  logic [W-1:0]  count_n, data, data_n, stepped;
  logic [PW-1:0] pre, pre_n;
  logic          dir, dir_n, err_n, done_n, acc, tick;
  function automatic logic bcd_ok(input logic [W-1:0] v);
    bcd_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) if (v[4*i+:4] > 4'd9) bcd_ok = 1'b0;
  endfunction
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
    logic c;
    c = 1'b1;
    bcd_step = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        bcd_step[4*i+:4] = up ? (v[4*i+:4] == 4'd9 ? 4'd0 : v[4*i+:4] + 4'd1)
                              : (v[4*i+:4] == 4'd0 ? 4'd9 : v[4*i+:4] - 4'd1);
        c = up ? (v[4*i+:4] == 4'd9) : (v[4*i+:4] == 4'd0);
      end
    end
  endfunction
  function automatic logic terminal(input logic [W-1:0] v, input logic up);
    terminal = up ? (v == {DIGITS{4'h9}}) : (v == '0);
  endfunction
  assign acc     = bus.cmd_valid && bus.cmd_ready;
  assign tick    = pre == PW'(TICK_DIV-1);
  assign stepped = bcd_step(count, dir);
  assign state   = st;
  always_comb begin
    state_n = st;
    count_n = count;
    err_n   = err;
    dir_n   = dir;
    pre_n   = pre;
    data_n  = data;
    done_n  = 1'b0;
    if (st == LD) begin
      count_n = bcd_ok(data) ? data : count;
      err_n   = err | ~bcd_ok(data);
      state_n = IDLE;
    end else if (acc && bus.cmd_op == OP_CLEAR) begin
      count_n = '0;
      err_n   = 1'b0;
      pre_n   = '0;
      state_n = IDLE;
    end else if (acc && bus.cmd_op == OP_LOAD) begin
      data_n  = bus.cmd_data;
      pre_n   = '0;
      state_n = LD;
    end else if (st == IDLE && acc && bus.cmd_op == OP_START) begin
      dir_n   = bus.cmd_dir;
      pre_n   = '0;
      done_n  = terminal(count, bus.cmd_dir);
      state_n = done_n ? DONE : RUN;
    end else if (st == PAUSE && acc && bus.cmd_op == OP_START) begin
      state_n = RUN;
    end else if (st == RUN) begin
      // the prescaler keeps advancing even when an accepted command discards the tick
      pre_n = tick ? '0 : pre + PW'(1);
      if (acc && bus.cmd_op == OP_STOP) state_n = PAUSE;
      else if (!acc && tick) begin
        count_n = stepped;
        if (terminal(stepped, dir)) begin
          state_n = DONE;
          done_n  = 1'b1;
          pre_n   = '0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      count         <= '0;
      err           <= 1'b0;
      dir           <= 1'b1;
      pre           <= '0;
      data          <= '0;
      done          <= 1'b0;
      running       <= 1'b0;
      bus.cmd_ready <= 1'b1;
    end else begin
      st            <= state_n;
      count         <= count_n;
      err           <= err_n;
      dir           <= dir_n;
      pre           <= pre_n;
      data          <= data_n;
      done          <= done_n;
      running       <= state_n == RUN;
      bus.cmd_ready <= state_n != LD;
    end
  end
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: directed and randomized checks of bcd_timer_ctrl against an integer-count model.
module tb_bcd_timer_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [11:0] count;
  logic [2:0]  state;
  logic        running, done, err;
  int n_chk = 0, n_err = 0;
  int m_cnt, m_st, m_pre, m_dir, m_err, m_done;
  logic [11:0] m_data;
  always #5 clk = ~clk;
  bcd_timer_ctrl_if #(.DIGITS(3)) bus ();
  bcd_timer_ctrl #(.DIGITS(3), .TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .count(count), .state(state),
    .running(running), .done(done), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [11:0] to_bcd(input int n);
    logic [11:0] b;
    b = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    return b;
  endfunction
  function automatic int from_bcd(input logic [11:0] b);
    return 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction
  function automatic bit is_bcd(input logic [11:0] b);
    return b[11:8] < 10 && b[7:4] < 10 && b[3:0] < 10;
  endfunction
  task automatic model(input logic r, input logic v, input logic [1:0] op, input logic [11:0] d, input logic dr);
    bit acc, tk;
    acc = v && m_st != 1;
    if (r) begin
      m_cnt = 0; m_st = 0; m_pre = 0; m_dir = 1; m_err = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (m_st == 1) begin
      if (is_bcd(m_data)) m_cnt = from_bcd(m_data);
      else m_err = 1;
      m_st = 0;
    end else if (acc && op == 2) begin
      m_cnt = 0; m_err = 0; m_pre = 0; m_st = 0;
    end else if (acc && op == 3) begin
      m_data = d; m_pre = 0; m_st = 1;
    end else if (m_st == 0 && acc && op == 0) begin
      m_dir = dr; m_pre = 0;
      m_done = (dr ? m_cnt == 999 : m_cnt == 0) ? 1 : 0;
      m_st = m_done ? 4 : 2;
    end else if (m_st == 3 && acc && op == 0) begin
      m_st = 2;
    end else if (m_st == 2) begin
      tk = m_pre == 3;
      m_pre = (m_pre + 1) % 4;
      if (acc && op == 1) m_st = 3;
      else if (!acc && tk) begin
        m_cnt += m_dir ? 1 : -1;
        if (m_dir ? m_cnt == 999 : m_cnt == 0) begin
          m_st = 4; m_done = 1; m_pre = 0;
        end
      end
    end
  endtask
  task automatic cyc(input logic r, input logic v, input logic [1:0] op, input logic [11:0] d, input logic dr);
    rst = r; bus.cmd_valid = v; bus.cmd_op = op; bus.cmd_data = d; bus.cmd_dir = dr;
    @(posedge clk);
    model(r, v, op, d, dr);
    #1;
    chk("count", 32'(count), 32'(to_bcd(m_cnt)));
    chk("state", 32'(state), 32'(m_st));
    chk("running", 32'(running), 32'(m_st == 2));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(m_st != 1));
  endtask
  task automatic cmd(input logic [1:0] op, input logic [11:0] d, input logic dr);
    cyc(1'b0, 1'b1, op, d, dr);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 12'h0, 1'b0);
  endtask
  initial begin
    m_data = '0;
    cyc(1'b1, 1'b0, 2'd0, 12'h0, 1'b0);
    cyc(1'b1, 1'b1, 2'd3, 12'h555, 1'b0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'h1);
    cmd(2'd3, 12'h095, 1'b0);
    idle(1);
    cmd(2'd0, 12'h0, 1'b1);
    idle(19);
    chk("up_099", 32'(count), 32'h099);
    idle(1);
    chk("up_100", 32'(count), 32'h100);
    cmd(2'd2, 12'h0, 1'b0);
    cmd(2'd3, 12'h003, 1'b0);
    idle(1);
    cmd(2'd0, 12'h0, 1'b0);
    idle(12);
    chk("dn_000", 32'(count), 32'h000);
    chk("dn_done", 32'(done), 32'h1);
    chk("dn_state", 32'(state), 32'h4);
    idle(1);
    chk("dn_done_off", 32'(done), 32'h0);
    cmd(2'd3, 12'h998, 1'b0);
    idle(1);
    cmd(2'd0, 12'h0, 1'b1);
    idle(4);
    chk("top_999", 32'(count), 32'h999);
    chk("top_done", 32'(done), 32'h1);
    idle(40);
    chk("no_wrap", 32'(count), 32'h999);
    cmd(2'd3, 12'h0A5, 1'b0);
    chk("ld_ready", 32'(bus.cmd_ready), 32'h0);
    idle(1);
    chk("bad_err", 32'(err), 32'h1);
    chk("bad_keep", 32'(count), 32'h999);
    chk("bad_idle", 32'(state), 32'h0);
    cmd(2'd2, 12'h0, 1'b0);
    chk("clr_err", 32'(err), 32'h0);
    chk("clr_cnt", 32'(count), 32'h000);
    cmd(2'd0, 12'h0, 1'b0);
    chk("start_term", 32'(state), 32'h4);
    cmd(2'd3, 12'h050, 1'b0);
    idle(1);
    cmd(2'd0, 12'h0, 1'b1);
    idle(3);
    cmd(2'd1, 12'h0, 1'b0);
    chk("stop_nostep", 32'(count), 32'h050);
    chk("stop_pause", 32'(state), 32'h3);
    idle(5);
    cmd(2'd0, 12'h0, 1'b0);
    idle(3);
    chk("resume_hold", 32'(count), 32'h050);
    idle(1);
    chk("resume_step", 32'(count), 32'h051);
    idle(6);
    cyc(1'b1, 1'b1, 2'd0, 12'h0, 1'b1);
    chk("rst_run_state", 32'(state), 32'h0);
    chk("rst_run_running", 32'(running), 32'h0);
    for (int i = 0; i < 4000; i++) begin
      logic [11:0] d;
      logic [1:0]  op;
      int c;
      c = int'($urandom_range(0, 99));
      op = 2'($urandom_range(0, 3));
      d = $urandom_range(0, 9) == 0 ? 12'($urandom) : to_bcd(int'($urandom_range(0, 999)));
      if (op == 2'd3 && $urandom_range(0, 2) == 0) d = $urandom_range(0, 1) ? 12'h998 : 12'h002;
      if (c == 0) cyc(1'b1, 1'($urandom), op, d, 1'($urandom));
      else cyc(1'b0, c < 8, op, d, 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
